// File: rtl/ring_interlock_ctrl.sv
// Ring interlock: forbidden closed-set inhibit, one-per-cycle round-robin close grants,
// coil/feedback supervision with timeout, and per-contactor fault latching.
module ring_interlock_ctrl #(
   parameter int unsigned                 N_CONT       = 8,
   parameter int unsigned                 N_SETS       = 7,
   parameter logic [N_SETS*N_CONT-1:0]    FORBID_MASKS = 56'h1EB6ADC66C071C,
   parameter int unsigned                 FB_TIMEOUT   = 16
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   input  logic [N_CONT-1:0] i_Req,
   input  logic [N_CONT-1:0] i_Fb,
   input  logic              i_FaultClr,
   output logic [N_CONT-1:0] o_Cmd,
   output logic [N_CONT-1:0] o_Closed,
   output logic [N_CONT-1:0] o_Blocked,
   output logic [N_CONT-1:0] o_Fault
);

   localparam int unsigned TW = $clog2(FB_TIMEOUT + 1);
   localparam int unsigned PW = (N_CONT > 1) ? $clog2(N_CONT) : 1;

   typedef enum logic [2:0] {StOpen, StClosing, StClosed, StOpening, StFault} state_e;

   state_e            r_state   [N_CONT];
   state_e            w_state_d [N_CONT];
   logic [TW-1:0]     r_timer   [N_CONT];
   logic [TW-1:0]     w_timer_d [N_CONT];
   logic [PW-1:0]     r_ptr, w_ptr_d;
   logic [N_CONT-1:0] r_fb_meta, r_fb_s;
   logic [N_CONT-1:0] w_occ, w_inhibit, w_elig, w_grant, w_blocked;
   logic [N_CONT-1:0] w_cmd_d, w_closed_d, w_fault_d;

   // A contactor is inhibited when closing it would complete some forbidden set.
   always_comb begin
      logic [N_CONT-1:0] set_v;
      logic [N_CONT-1:0] miss;
      logic [PW-1:0]     idx;
      logic              found;
      set_v     = '0;
      miss      = '0;
      idx       = '0;
      found     = 1'b0;
      w_occ     = '0;
      w_inhibit = '0;
      w_elig    = '0;
      w_blocked = '0;
      w_grant   = '0;
      w_ptr_d   = r_ptr;
      for (int k = 0; k < int'(N_CONT); k++) begin
         w_occ[k] = (r_state[k] != StOpen) | r_fb_s[k];
      end
      for (int k = 0; k < int'(N_CONT); k++) begin
         for (int s = 0; s < int'(N_SETS); s++) begin
            set_v   = FORBID_MASKS[s*N_CONT +: N_CONT];
            miss    = set_v & ~w_occ;
            miss[k] = 1'b0;
            if (set_v[k] && (miss == '0)) begin
               w_inhibit[k] = 1'b1;
            end
         end
         w_elig[k]    = i_Req[k] & (r_state[k] == StOpen) & ~r_fb_s[k] & ~w_inhibit[k];
         w_blocked[k] = i_Req[k] & (r_state[k] == StOpen) & ~r_fb_s[k] & w_inhibit[k];
      end
      // Single grant per cycle so two closes can never jointly complete a set.
      for (int i = 0; i < int'(N_CONT); i++) begin
         idx = PW'((int'(r_ptr) + i) % int'(N_CONT));
         if (!found && w_elig[idx]) begin
            found        = 1'b1;
            w_grant[idx] = 1'b1;
            w_ptr_d      = PW'((int'(r_ptr) + i + 1) % int'(N_CONT));
         end
      end
   end

   always_comb begin
      for (int k = 0; k < int'(N_CONT); k++) begin
         w_state_d[k] = r_state[k];
         unique case (r_state[k])
            StOpen: begin
               if (r_fb_s[k])        w_state_d[k] = StFault;
               else if (w_grant[k])  w_state_d[k] = StClosing;
            end
            StClosing: begin
               if (r_fb_s[k])                                w_state_d[k] = StClosed;
               else if (!i_Req[k])                           w_state_d[k] = StOpening;
               else if (r_timer[k] == TW'(FB_TIMEOUT - 1))   w_state_d[k] = StFault;
            end
            StClosed: begin
               if (!r_fb_s[k])       w_state_d[k] = StFault;
               else if (!i_Req[k])   w_state_d[k] = StOpening;
            end
            StOpening: begin
               if (!r_fb_s[k])                               w_state_d[k] = StOpen;
               else if (r_timer[k] == TW'(FB_TIMEOUT - 1))   w_state_d[k] = StFault;
            end
            StFault: begin
               if (i_FaultClr && !i_Req[k]) w_state_d[k] = StOpening;
            end
            default: w_state_d[k] = StOpen;
         endcase

         if (w_state_d[k] != r_state[k]) begin
            w_timer_d[k] = '0;
         end else if (((r_state[k] == StClosing) || (r_state[k] == StOpening)) &&
                      (r_timer[k] != TW'(FB_TIMEOUT))) begin
            w_timer_d[k] = r_timer[k] + TW'(1);
         end else begin
            w_timer_d[k] = r_timer[k];
         end
      end
   end

   always_comb begin
      w_cmd_d    = '0;
      w_closed_d = '0;
      w_fault_d  = '0;
      for (int k = 0; k < int'(N_CONT); k++) begin
         w_cmd_d[k]    = (w_state_d[k] == StClosing) || (w_state_d[k] == StClosed);
         w_closed_d[k] = (w_state_d[k] == StClosed);
         w_fault_d[k]  = (w_state_d[k] == StFault);
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         for (int k = 0; k < int'(N_CONT); k++) begin
            r_state[k] <= StOpen;
            r_timer[k] <= '0;
         end
         r_ptr     <= '0;
         r_fb_meta <= '0;
         r_fb_s    <= '0;
         o_Cmd     <= '0;
         o_Closed  <= '0;
         o_Blocked <= '0;
         o_Fault   <= '0;
      end else begin
         for (int k = 0; k < int'(N_CONT); k++) begin
            r_state[k] <= w_state_d[k];
            r_timer[k] <= w_timer_d[k];
         end
         r_ptr     <= w_ptr_d;
         r_fb_meta <= i_Fb;
         r_fb_s    <= r_fb_meta;
         o_Cmd     <= w_cmd_d;
         o_Closed  <= w_closed_d;
         o_Blocked <= w_blocked;
         o_Fault   <= w_fault_d;
      end
   end

endmodule

// File: tb/tb_ring_interlock_ctrl.sv
// Bench for ring_interlock_ctrl: directed scenarios, a per-cycle spec-level model check,
// and hand-computed literal expectations.
module tb_ring_interlock_ctrl;

   localparam int          TO    = 16;
   localparam logic [55:0] MASKS = 56'h1EB6ADC66C071C;
   localparam int M_OPEN = 0, M_CLOSING = 1, M_CLOSED = 2, M_OPENING = 3, M_FAULT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [7:0] fb;
   logic       fault_clr;
   logic [7:0] cmd, closed, blocked, fault;

   // Plant: feedback follows the coil through two flops; tests can pin or force it.
   logic [7:0] pl0 = '0, pl1 = '0;
   logic [7:0] stuck0 = '0, force1 = '0;
   assign fb = (pl1 & ~stuck0) | force1;

   int n_chk = 0;
   int n_err = 0;
   int wait_n;

   int         m_mode [8];
   int         m_age  [8];
   int         m_ptr;
   logic [7:0] m_h1, m_h2;
   logic [7:0] e_cmd = '0, e_closed = '0, e_blocked = '0, e_fault = '0;

   ring_interlock_ctrl dut (
      .i_Clk      (clk),
      .i_Rst      (rst),
      .i_Req      (req),
      .i_Fb       (fb),
      .i_FaultClr (fault_clr),
      .o_Cmd      (cmd),
      .o_Closed   (closed),
      .o_Blocked  (blocked),
      .o_Fault    (fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      pl0 <= cmd;
      pl1 <= pl0;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   // Spec-level model, advanced once per rising edge with the inputs seen at that edge.
   task automatic model_step();
      logic [7:0] fbs, occ, inh, elig, set_v;
      int         g, idx, nm;
      if (rst) begin
         for (int k = 0; k < 8; k++) begin
            m_mode[k] = M_OPEN;
            m_age[k]  = 0;
         end
         m_ptr = 0; m_h1 = '0; m_h2 = '0;
         e_cmd = '0; e_closed = '0; e_blocked = '0; e_fault = '0;
         return;
      end
      fbs  = m_h2;
      m_h2 = m_h1;
      m_h1 = fb;
      occ = '0; inh = '0; elig = '0;
      for (int k = 0; k < 8; k++) occ[k] = (m_mode[k] != M_OPEN) || fbs[k];
      for (int k = 0; k < 8; k++) begin
         for (int s = 0; s < 7; s++) begin
            set_v = MASKS[s*8 +: 8];
            if (set_v[k] && (((occ | (8'b1 << k)) & set_v) == set_v)) inh[k] = 1'b1;
         end
         elig[k]      = req[k] && (m_mode[k] == M_OPEN) && !fbs[k] && !inh[k];
         e_blocked[k] = req[k] && (m_mode[k] == M_OPEN) && !fbs[k] && inh[k];
      end
      g = -1;
      for (int i = 0; i < 8; i++) begin
         idx = (m_ptr + i) % 8;
         if (g < 0 && elig[idx]) g = idx;
      end
      if (g >= 0) m_ptr = (g + 1) % 8;
      for (int k = 0; k < 8; k++) begin
         case (m_mode[k])
            M_OPEN:    nm = fbs[k] ? M_FAULT : ((g == k) ? M_CLOSING : M_OPEN);
            M_CLOSING: nm = fbs[k] ? M_CLOSED : (!req[k] ? M_OPENING :
                            ((m_age[k] == TO - 1) ? M_FAULT : M_CLOSING));
            M_CLOSED:  nm = !fbs[k] ? M_FAULT : (!req[k] ? M_OPENING : M_CLOSED);
            M_OPENING: nm = !fbs[k] ? M_OPEN : ((m_age[k] == TO - 1) ? M_FAULT : M_OPENING);
            default:   nm = (fault_clr && !req[k]) ? M_OPENING : M_FAULT;
         endcase
         if (nm != m_mode[k]) m_age[k] = 0;
         else if (nm == M_CLOSING || nm == M_OPENING) m_age[k] = (m_age[k] < TO) ? m_age[k] + 1 : TO;
         m_mode[k]   = nm;
         e_cmd[k]    = (nm == M_CLOSING) || (nm == M_CLOSED);
         e_closed[k] = (nm == M_CLOSED);
         e_fault[k]  = (nm == M_FAULT);
      end
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      check("model cmd", cmd, e_cmd);
      check("model closed", closed, e_closed);
      check("model blocked", blocked, e_blocked);
      check("model fault", fault, e_fault);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req = '0; fault_clr = 1'b0;

      // Reset with random inputs
      for (int i = 0; i < 4; i++) begin
         req    = 8'($urandom_range(255));
         force1 = 8'($urandom_range(255));
         @(negedge clk);
         check("rst cmd", cmd, 8'h00);
         check("rst fault", fault, 8'h00);
      end
      rst = 1'b0; req = '0; force1 = '0;
      @(negedge clk);
      check("post-rst cmd", cmd, 8'h00);
      check("post-rst closed", closed, 8'h00);
      check("post-rst blocked", blocked, 8'h00);
      check("post-rst fault", fault, 8'h00);

      // Close and open C
      req[2] = 1'b1;
      @(negedge clk);
      check1("t2 cmd2 rise", cmd[2], 1'b1);
      check1("t2 closed2 early", closed[2], 1'b0);
      repeat (4) @(negedge clk);
      check1("t2 closed2 at +4", closed[2], 1'b0);
      @(negedge clk);
      check1("t2 closed2 at +5", closed[2], 1'b1);
      req[2] = 1'b0;
      @(negedge clk);
      check1("t2 cmd2 drop", cmd[2], 1'b0);
      repeat (8) @(negedge clk);
      check("t2 idle fault", fault, 8'h00);

      // D,E closed block C until E reopens
      req[3] = 1'b1; req[4] = 1'b1;
      repeat (10) @(negedge clk);
      check("t3 D,E closed", closed, 8'h18);
      req[2] = 1'b1;
      @(negedge clk);
      check1("t3 blocked2", blocked[2], 1'b1);
      check1("t3 cmd2 held", cmd[2], 1'b0);
      req[4] = 1'b0;
      wait_n = 0;
      while (cmd[2] !== 1'b1 && wait_n < 30) begin
         @(negedge clk);
         wait_n++;
      end
      check1("t3 C granted after E opens", cmd[2], 1'b1);
      check1("t3 blocked2 cleared", blocked[2], 1'b0);
      repeat (8) @(negedge clk);
      req = '0;
      repeat (12) @(negedge clk);

      // Pointer to 0 via H grant, E closed; simultaneous C,D requests
      req[4] = 1'b1; req[7] = 1'b1;
      repeat (10) @(negedge clk);
      req[2] = 1'b1; req[3] = 1'b1;
      @(negedge clk);
      check1("t4 cmd2 granted", cmd[2], 1'b1);
      check1("t4 cmd3 lost", cmd[3], 1'b0);
      check1("t4 blocked3 not on loss", blocked[3], 1'b0);
      @(negedge clk);
      check1("t4 blocked3", blocked[3], 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check1("t4 C and D both commanded", cmd[2] & cmd[3], 1'b0);
      end
      req = '0;
      repeat (12) @(negedge clk);

      // F feedback stuck open: timeout fault and clear
      stuck0[5] = 1'b1; req[5] = 1'b1;
      @(negedge clk);
      check1("t5 cmd5 rise", cmd[5], 1'b1);
      repeat (15) @(negedge clk);
      check1("t5 fault5 before timeout", fault[5], 1'b0);
      check1("t5 cmd5 before timeout", cmd[5], 1'b1);
      @(negedge clk);
      check1("t5 fault5 at timeout", fault[5], 1'b1);
      check1("t5 cmd5 at timeout", cmd[5], 1'b0);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      check1("t5 clear with req high", fault[5], 1'b1);
      req[5] = 1'b0; fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      check1("t5 clear with req low", fault[5], 1'b0);
      repeat (3) @(negedge clk);
      stuck0 = '0;

      // Uncommanded G closure while B is closing
      req[1] = 1'b1;
      repeat (2) @(negedge clk);
      force1[6] = 1'b1;
      repeat (2) @(negedge clk);
      check1("t6 fault6 at edge 2", fault[6], 1'b0);
      @(negedge clk);
      check1("t6 fault6 at edge 3", fault[6], 1'b1);
      repeat (6) @(negedge clk);
      check1("t6 B closed", closed[1], 1'b1);
      check1("t6 B no fault", fault[1], 1'b0);

      // Reset mid-operation with G feedback still high
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("t6 rst cmd", cmd, 8'h00);
      check("t6 rst fault", fault, 8'h00);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check1("t6 post-rst fault6 edge 2", fault[6], 1'b0);
      @(negedge clk);
      check1("t6 post-rst fault6 edge 3", fault[6], 1'b1);
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
